chip8_alu_seq: RTL and testbench

Parametrised, handshaked successor to the CHIP-8 execution ALU. It executes the 8xyN arithmetic and logic group plus an iterative binary-to-BCD conversion (the Fx33 datapath). Operations are exchanged over valid/ready channels, and results are held in a one-entry output register. It sits between the decode/register-file stage, which drives operands, and the write-back stage, which writes `result` to Vx and `flag` to VF.

---
 rtl/chip8_alu_seq.sv | 212 +++++++++++++++++++++
 tb/tb_chip8_alu_seq.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chip8_alu_seq.sv
// CHIP-8 8xyN arithmetic/logic unit with an iterative double-dabble BCD path (Fx33).
// Valid/ready on both sides; results sit in a one-entry output register until drained.
module chip8_alu_seq #(
    parameter int WIDTH        = 8,
    parameter int BCD_DIGITS   = 3,
    parameter int SHIFT_SRC_VX = 0,
    parameter int LOGIC_CLR_VF = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [3:0]              opcode,
    input  logic [WIDTH-1:0]        op1,
    input  logic [WIDTH-1:0]        op2,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        result,
    output logic                    flag,
    output logic                    flag_we,
    output logic [4*BCD_DIGITS-1:0] bcd,
    output logic                    err
);

    localparam int BW = 4 * BCD_DIGITS;
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BCD  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]    acc_q, acc_d;

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             flag_q, flag_d;
    logic             flag_we_q, flag_we_d;
    logic             err_q, err_d;
    logic [BW-1:0]    bcd_q, bcd_d;

    logic             accept;
    logic             is_bcd_op;
    logic             last_step;
    logic [BW-1:0]    acc_step;
    logic [WIDTH-1:0] shift_rot;

    logic [WIDTH-1:0] alu_res;
    logic             alu_flag;
    logic             alu_we;
    logic             alu_err;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] src;

    // One double-dabble iteration: correct digits >= 5, then shift in the next binary bit.
    function automatic logic [BW-1:0] dd_step(input logic [BW-1:0] a, input logic b);
        logic [BW-1:0] t;
        t = a;
        for (int i = 0; i < BCD_DIGITS; i++) begin
            if (t[4*i +: 4] >= 4'd5) begin
                t[4*i +: 4] = t[4*i +: 4] + 4'd3;
            end
        end
        return {t[BW-2:0], b};
    endfunction

    assign in_ready  = rst_n && (state_q == S_IDLE) && (!out_valid_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_bcd_op = (opcode == 4'hF);
    assign last_step = (state_q == S_BCD) && (cnt_q == CW'(WIDTH - 1));
    assign acc_step  = dd_step(acc_q, shift_q[WIDTH-1]);
    // Rotating rather than shifting returns op1 intact after WIDTH steps.
    assign shift_rot = {shift_q[WIDTH-2:0], shift_q[WIDTH-1]};

    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        alu_we   = 1'b0;
        alu_err  = 1'b0;
        sum      = {1'b0, op1} + {1'b0, op2};
        src      = (SHIFT_SRC_VX != 0) ? op1 : op2;
        case (opcode)
            4'h0: alu_res = op2;
            4'h1: begin
                alu_res = op1 | op2;
                alu_we  = (LOGIC_CLR_VF != 0);
            end
            4'h2: begin
                alu_res = op1 & op2;
                alu_we  = (LOGIC_CLR_VF != 0);
            end
            4'h3: begin
                alu_res = op1 ^ op2;
                alu_we  = (LOGIC_CLR_VF != 0);
            end
            4'h4: begin
                alu_res  = sum[WIDTH-1:0];
                alu_flag = sum[WIDTH];
                alu_we   = 1'b1;
            end
            4'h5: begin
                alu_res  = op1 - op2;
                alu_flag = (op1 >= op2);
                alu_we   = 1'b1;
            end
            4'h6: begin
                alu_res  = src >> 1;
                alu_flag = src[0];
                alu_we   = 1'b1;
            end
            4'h7: begin
                alu_res  = op2 - op1;
                alu_flag = (op2 >= op1);
                alu_we   = 1'b1;
            end
            4'hE: begin
                alu_res  = src << 1;
                alu_flag = src[WIDTH-1];
                alu_we   = 1'b1;
            end
            4'hF: alu_res = op1;
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_bcd_op) begin
                    state_d = S_BCD;
                    cnt_d   = '0;
                    shift_d = op1;
                    acc_d   = '0;
                end
            end
            S_BCD: begin
                shift_d = shift_rot;
                acc_d   = acc_step;
                cnt_d   = cnt_q + CW'(1);
                if (last_step) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        result_d    = result_q;
        flag_d      = flag_q;
        flag_we_d   = flag_we_q;
        err_d       = err_q;
        bcd_d       = bcd_q;
        if (accept && !is_bcd_op) begin
            out_valid_d = 1'b1;
            result_d    = alu_res;
            flag_d      = alu_flag;
            flag_we_d   = alu_we;
            err_d       = alu_err;
        end else if (last_step) begin
            out_valid_d = 1'b1;
            result_d    = shift_rot;
            flag_d      = 1'b0;
            flag_we_d   = 1'b0;
            err_d       = 1'b0;
            bcd_d       = acc_step;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            shift_q     <= '0;
            acc_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= 1'b0;
            flag_we_q   <= 1'b0;
            err_q       <= 1'b0;
            bcd_q       <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            acc_q       <= acc_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            flag_q      <= flag_d;
            flag_we_q   <= flag_we_d;
            err_q       <= err_d;
            bcd_q       <= bcd_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign flag      = flag_q;
    assign flag_we   = flag_we_q;
    assign err       = err_q;
    assign bcd       = bcd_q;

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Bench for chip8_alu_seq: two instances (default quirks, and shift-from-Vx + logic-clears-VF)
// share one stimulus stream and are each compared against an arithmetic reference model.
module tb_chip8_alu_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [3:0] opcode;
    logic [7:0] op1;
    logic [7:0] op2;
    logic       out_ready;

    logic        in_ready_a, out_valid_a, flag_a, flag_we_a, err_a;
    logic [7:0]  result_a;
    logic [11:0] bcd_a;
    logic        in_ready_b, out_valid_b, flag_b, flag_we_b, err_b;
    logic [7:0]  result_b;
    logic [11:0] bcd_b;

    logic [23:0] obs_a, obs_b;
    assign obs_a = {out_valid_a, err_a, flag_we_a, flag_a, result_a, bcd_a};
    assign obs_b = {out_valid_b, err_b, flag_we_b, flag_b, result_b, bcd_b};

    int checks   = 0;
    int failures = 0;
    logic [11:0] exp_bcd;

    always #5 clk = ~clk;

    chip8_alu_seq #(.WIDTH(8), .BCD_DIGITS(3), .SHIFT_SRC_VX(0), .LOGIC_CLR_VF(0)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_a),
        .opcode(opcode), .op1(op1), .op2(op2), .out_valid(out_valid_a),
        .out_ready(out_ready), .result(result_a), .flag(flag_a), .flag_we(flag_we_a),
        .bcd(bcd_a), .err(err_a)
    );

    chip8_alu_seq #(.WIDTH(8), .BCD_DIGITS(3), .SHIFT_SRC_VX(1), .LOGIC_CLR_VF(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_b),
        .opcode(opcode), .op1(op1), .op2(op2), .out_valid(out_valid_b),
        .out_ready(out_ready), .result(result_b), .flag(flag_b), .flag_we(flag_we_b),
        .bcd(bcd_b), .err(err_b)
    );

    // Expected {out_valid, err, flag_we, flag, result, bcd} once an operation completes.
    function automatic logic [23:0] model(input logic [3:0] op, input logic [7:0] a,
                                          input logic [7:0] b, input bit shvx, input bit lclr,
                                          input logic [11:0] pbcd);
        logic [7:0]  r;
        logic [7:0]  src;
        logic        f, we, e;
        logic [11:0] bc;
        int          s;
        r = 8'h00; f = 1'b0; we = 1'b0; e = 1'b0; bc = pbcd;
        src = shvx ? a : b;
        case (op)
            4'h0: r = b;
            4'h1: begin r = a | b; we = lclr; end
            4'h2: begin r = a & b; we = lclr; end
            4'h3: begin r = a ^ b; we = lclr; end
            4'h4: begin
                s = int'(a) + int'(b);
                r = 8'(s % 256); f = (s > 255); we = 1'b1;
            end
            4'h5: begin
                s = int'(a) - int'(b);
                r = 8'((s + 256) % 256); f = (int'(a) >= int'(b)); we = 1'b1;
            end
            4'h6: begin
                r = src / 8'd2; f = ((src % 8'd2) == 8'd1); we = 1'b1;
            end
            4'h7: begin
                s = int'(b) - int'(a);
                r = 8'((s + 256) % 256); f = (int'(b) >= int'(a)); we = 1'b1;
            end
            4'hE: begin
                r = 8'((int'(src) * 2) % 256); f = (src >= 8'd128); we = 1'b1;
            end
            4'hF: begin
                r = a;
                bc = {4'(a / 8'd100), 4'((a / 8'd10) % 8'd10), 4'(a % 8'd10)};
            end
            default: e = 1'b1;
        endcase
        return {1'b1, e, we, f, r, bc};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; opcode = 4'h0; op1 = 8'h00; op2 = 8'h00;
        out_ready = 1'b1; exp_bcd = 12'h000;
        #1;
        checks++;
        if (obs_a !== 24'h0 || obs_b !== 24'h0) begin
            failures++;
            $display("FAIL reset_outputs got a=%h b=%h exp=000000", obs_a, obs_b);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_in_ready got a=%b b=%b exp=0", in_ready_a, in_ready_b);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
            failures++;
            $display("FAIL release_in_ready got a=%b b=%b exp=1", in_ready_a, in_ready_b);
        end
    endtask

    task automatic test_single_ops();
        logic [3:0]  ops [11] = '{4'h4, 4'h5, 4'h5, 4'h7, 4'h6, 4'hE, 4'h1, 4'h9, 4'h0, 4'h2, 4'h3};
        logic [7:0]  va  [11] = '{8'hFF, 8'h10, 8'h20, 8'h20, 8'h05, 8'h03, 8'hF0, 8'h55, 8'h12, 8'hF0, 8'hAA};
        logic [7:0]  vb  [11] = '{8'h01, 8'h20, 8'h20, 8'h10, 8'h81, 8'h81, 8'h0F, 8'h66, 8'h34, 8'h3C, 8'hFF};
        logic [23:0] ea, eb;
        logic [3:0]  op;
        logic [7:0]  a, b;
        for (int i = 0; i < 51; i++) begin
            if (i < 11) begin
                op = ops[i]; a = va[i]; b = vb[i];
            end else begin
                op = 4'($urandom_range(0, 14)); a = 8'($urandom); b = 8'($urandom);
            end
            @(negedge clk);
            in_valid = 1'b1; opcode = op; op1 = a; op2 = b; out_ready = 1'b1;
            checks++;
            if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
                failures++;
                $display("FAIL stream_in_ready op=%h got a=%b b=%b exp=1", op, in_ready_a, in_ready_b);
            end
            ea = model(op, a, b, 1'b0, 1'b0, exp_bcd);
            eb = model(op, a, b, 1'b1, 1'b1, exp_bcd);
            @(posedge clk); #1;
            checks++;
            if (obs_a !== ea) begin
                failures++;
                $display("FAIL single_a op=%h a=%h b=%h got=%h exp=%h", op, a, b, obs_a, ea);
            end
            checks++;
            if (obs_b !== eb) begin
                failures++;
                $display("FAIL single_b op=%h a=%h b=%h got=%h exp=%h", op, a, b, obs_b, eb);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_bcd();
        logic [7:0]  vals [8];
        logic [23:0] ea, eb;
        vals[0] = 8'hFF; vals[1] = 8'h00; vals[2] = 8'h64;
        for (int i = 3; i < 8; i++) vals[i] = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            in_valid = 1'b1; opcode = 4'hF; op1 = vals[i]; op2 = 8'($urandom); out_ready = 1'b1;
            checks++;
            if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
                failures++;
                $display("FAIL bcd_accept_ready got a=%b b=%b exp=1", in_ready_a, in_ready_b);
            end
            ea = model(4'hF, vals[i], op2, 1'b0, 1'b0, exp_bcd);
            eb = model(4'hF, vals[i], op2, 1'b1, 1'b1, exp_bcd);
            @(posedge clk); #1;
            in_valid = 1'b0;
            for (int c = 0; c < 8; c++) begin
                checks++;
                if ({in_ready_a, out_valid_a, in_ready_b, out_valid_b} !== 4'b0000) begin
                    failures++;
                    $display("FAIL bcd_busy cyc=%0d got rdy/vld a=%b%b b=%b%b exp=00",
                             c, in_ready_a, out_valid_a, in_ready_b, out_valid_b);
                end
                @(posedge clk); #1;
            end
            checks++;
            if (obs_a !== ea || obs_b !== eb) begin
                failures++;
                $display("FAIL bcd_result v=%h got a=%h b=%h exp a=%h b=%h", vals[i], obs_a, obs_b, ea, eb);
            end
            if (i == 0) begin
                checks++;
                if (bcd_a !== 12'h255) begin
                    failures++;
                    $display("FAIL bcd_ff got=%h exp=255", bcd_a);
                end
            end
            checks++;
            if (in_ready_a !== 1'b1) begin
                failures++;
                $display("FAIL bcd_done_ready got=%b exp=1", in_ready_a);
            end
            exp_bcd = ea[11:0];
        end
    endtask

    task automatic test_backpressure();
        logic [23:0] ea, eb;
        logic [7:0]  a, b, x, y;
        a = 8'($urandom); b = 8'($urandom); x = 8'($urandom); y = 8'($urandom);
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'h4; op1 = a; op2 = b; out_ready = 1'b0;
        ea = model(4'h4, a, b, 1'b0, 1'b0, exp_bcd);
        eb = model(4'h4, a, b, 1'b1, 1'b1, exp_bcd);
        @(posedge clk); #1;
        opcode = 4'h3; op1 = x; op2 = y;
        checks++;
        if (obs_a !== ea || obs_b !== eb) begin
            failures++;
            $display("FAIL bp_add got a=%h b=%h exp a=%h b=%h", obs_a, obs_b, ea, eb);
        end
        repeat (5) begin
            @(posedge clk); #1;
            checks++;
            if (obs_a !== ea || obs_b !== eb || in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold got a=%h b=%h rdy=%b%b exp a=%h b=%h rdy=00",
                         obs_a, obs_b, in_ready_a, in_ready_b, ea, eb);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        checks++;
        if (in_ready_a !== 1'b1 || in_ready_b !== 1'b1) begin
            failures++;
            $display("FAIL bp_release_ready got a=%b b=%b exp=1", in_ready_a, in_ready_b);
        end
        ea = model(4'h3, x, y, 1'b0, 1'b0, exp_bcd);
        eb = model(4'h3, x, y, 1'b1, 1'b1, exp_bcd);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (obs_a !== ea || obs_b !== eb) begin
            failures++;
            $display("FAIL bp_xor got a=%h b=%h exp a=%h b=%h", obs_a, obs_b, ea, eb);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
            failures++;
            $display("FAIL drain got a=%b b=%b exp=0", out_valid_a, out_valid_b);
        end
    endtask

    task automatic test_reset_mid_bcd();
        logic [23:0] ea;
        @(negedge clk);
        in_valid = 1'b1; opcode = 4'hF; op1 = 8'hFF; op2 = 8'h00; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        exp_bcd = 12'h000;
        checks++;
        if (obs_a !== 24'h0 || obs_b !== 24'h0 || in_ready_a !== 1'b0 || in_ready_b !== 1'b0) begin
            failures++;
            $display("FAIL async_reset got a=%h b=%h rdy=%b%b exp=000000 rdy=00",
                     obs_a, obs_b, in_ready_a, in_ready_b);
        end
        @(posedge clk); #1;
        checks++;
        if (out_valid_a !== 1'b0 || out_valid_b !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold got a=%b b=%b exp=0", out_valid_a, out_valid_b);
        end
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; opcode = 4'h4; op1 = 8'h03; op2 = 8'h04;
        ea = model(4'h4, 8'h03, 8'h04, 1'b0, 1'b0, exp_bcd);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checks++;
        if (result_a !== 8'h07 || obs_a !== ea || obs_b !== ea) begin
            failures++;
            $display("FAIL post_reset_add got a=%h b=%h exp=%h", obs_a, obs_b, ea);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_ops();
        test_bcd();
        test_backpressure();
        test_reset_mid_bcd();
        test_single_ops();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
